ux607_sticky_status_reader: RTL and testbench

- Read-side counterpart to the team's async-reset enabled register vectors.
- Bits are set by single-cycle event pulses from peripheral logic. They stay set ("sticky") until software reads them through a valid/ready request/response port.
- A read can optionally clear the bits it returned ("read-to-clear").
- Also counts lost events and raises a level interrupt while any bit is set.
- Sits between peripheral event sources and the peripheral bus register decoder.

---
 rtl/ux607_sticky_status_reader.sv | 95 +++++++++
 tb/tb_ux607_sticky_status_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ux607_sticky_status_reader.sv
// Sticky status bits set by event pulses, read through a valid/ready port with
// optional read-to-clear, plus a saturating lost-event counter and level irq.
module ux607_sticky_status_reader #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_set,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic             io_req_clr,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [WIDTH-1:0] io_resp_data,
  output logic [CNT_W-1:0] io_resp_ovf,
  output logic             io_irq
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] status_q, status_d, clr_mask, resp_data_q;
  logic [CNT_W-1:0] ovf_q, ovf_d, resp_ovf_q;
  logic             irq_q;
  logic             req_fire, resp_fire, lost;

  assign io_req_ready  = (state_q == StIdle);
  assign io_resp_valid = (state_q == StResp);
  assign io_resp_data  = resp_data_q;
  assign io_resp_ovf   = resp_ovf_q;
  assign io_irq        = irq_q;

  assign req_fire  = io_req_valid & io_req_ready;
  assign resp_fire = io_resp_valid & io_resp_ready;

  // Next status and lost-event count; set beats a same-cycle clear.
  always_comb begin
    clr_mask = '0;
    ovf_d    = ovf_q;
    lost     = |(io_set & status_q);
    if (req_fire && io_req_clr) begin
      clr_mask = status_q;
    end
    status_d = (status_q & ~clr_mask) | io_set;
    if (req_fire && io_req_clr) begin
      // Counter restarts; an event lost in the clearing cycle still counts.
      ovf_d = lost ? CntOne : '0;
    end else if (lost && (ovf_q != CntMax)) begin
      ovf_d = ovf_q + CntOne;
    end
  end

  // Sticky status, lost counter and irq registered from the next status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_q <= '0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      ovf_q    <= ovf_d;
      irq_q    <= |status_d;
    end
  end

  // Request/response FSM with snapshot registers held until handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      resp_data_q <= '0;
      resp_ovf_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            resp_data_q <= status_q;
            resp_ovf_q  <= ovf_q;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (resp_fire) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ux607_sticky_status_reader.sv
// Randomized and directed bench for the sticky status reader, checked against
// a cycle-level behavioural model of the read protocol and status rules.
module tb_ux607_sticky_status_reader;

  logic       clock;
  logic       reset;
  logic [2:0] io_set;
  logic       io_req_valid;
  logic       io_req_ready;
  logic       io_req_clr;
  logic       io_resp_valid;
  logic       io_resp_ready;
  logic [2:0] io_resp_data;
  logic [3:0] io_resp_ovf;
  logic       io_irq;

  ux607_sticky_status_reader #(
    .WIDTH(3),
    .CNT_W(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_set       (io_set),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_req_clr   (io_req_clr),
    .io_resp_valid(io_resp_valid),
    .io_resp_ready(io_resp_ready),
    .io_resp_data (io_resp_data),
    .io_resp_ovf  (io_resp_ovf),
    .io_irq       (io_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: status bits, lost count, pending response and its snapshot.
  logic [2:0] m_status;
  int         m_ovf;
  bit         m_busy;
  logic [2:0] m_rdata;
  int         m_rovf;

  logic [2:0] last_data;
  logic [3:0] last_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = '0;
    m_ovf    = 0;
    m_busy   = 1'b0;
    m_rdata  = '0;
    m_rovf   = 0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model.
  task automatic cycle(input logic [2:0] s, input logic v, input logic c, input logic r);
    bit accepted;
    bit lost;
    io_set        = s;
    io_req_valid  = v;
    io_req_clr    = c;
    io_resp_ready = r;
    @(negedge clock);
    chk("req_ready", io_req_ready, !m_busy);
    chk("resp_valid", io_resp_valid, m_busy);
    chk("irq", io_irq, m_status != 0);
    if (m_busy) begin
      chk("resp_data", io_resp_data, m_rdata);
      chk("resp_ovf", io_resp_ovf, m_rovf);
      if (r) begin
        last_data = io_resp_data;
        last_ovf  = io_resp_ovf;
      end
    end
    accepted = !m_busy && v;
    lost     = (s & m_status) != 0;
    if (accepted) begin
      m_rdata = m_status;
      m_rovf  = m_ovf;
    end
    if (accepted && c) begin
      m_status = s;
      m_ovf    = lost ? 1 : 0;
    end else begin
      m_status = m_status | s;
      if (lost && m_ovf < 15) m_ovf = m_ovf + 1;
    end
    if (m_busy && r) m_busy = 1'b0;
    if (accepted) m_busy = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic read(input logic c, output logic [2:0] d, output logic [3:0] o);
    cycle(3'b000, 1'b1, c, 1'b1);
    cycle(3'b000, 1'b0, 1'b0, 1'b1);
    d = last_data;
    o = last_ovf;
  endtask

  logic [2:0] rd;
  logic [3:0] ro;

  initial begin
    reset         = 1'b0;
    io_set        = '0;
    io_req_valid  = 1'b0;
    io_req_clr    = 1'b0;
    io_resp_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_resp_valid", io_resp_valid, 1'b0);
    chk("rst_irq", io_irq, 1'b0);
    chk("rst_data", io_resp_data, 3'b000);
    chk("rst_ovf", io_resp_ovf, 4'd0);
    reset = 1'b1;
    #1;
    chk("idle_ready", io_req_ready, 1'b1);

    // Reset then idle read.
    read(1'b0, rd, ro);
    chk("idle_rd_data", rd, 3'b000);
    chk("idle_rd_ovf", ro, 4'd0);

    // Sticky set and non-clearing reads.
    cycle(3'b101, 1'b0, 1'b0, 1'b0);
    chk("sticky_irq", io_irq, 1'b1);
    read(1'b0, rd, ro);
    chk("sticky_rd1", rd, 3'b101);
    chk("sticky_ovf", ro, 4'd0);
    read(1'b0, rd, ro);
    chk("sticky_rd2", rd, 3'b101);

    // Read-to-clear with same-cycle event on a set bit.
    read(1'b1, rd, ro);
    chk("clr_all", rd, 3'b101);
    cycle(3'b011, 1'b0, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, 1'b1, 1'b1);
    cycle(3'b000, 1'b0, 1'b0, 1'b1);
    chk("r2c_data", last_data, 3'b011);
    chk("r2c_irq", io_irq, 1'b1);
    read(1'b0, rd, ro);
    chk("r2c_after", rd, 3'b001);
    chk("r2c_ovf", ro, 4'd1);

    // Lost-event saturation.
    for (int i = 0; i < 20; i++) cycle(3'b001, 1'b0, 1'b0, 1'b0);
    read(1'b0, rd, ro);
    chk("sat_ovf", ro, 4'd15);
    read(1'b1, rd, ro);
    chk("sat_ovf_clr", ro, 4'd15);
    read(1'b0, rd, ro);
    chk("sat_ovf_zero", ro, 4'd0);
    chk("sat_data_zero", rd, 3'b000);

    // Response backpressure with events arriving during the hold.
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(3'b100, 1'b1, 1'b0, 1'b0);
      chk("bp_data", io_resp_data, 3'b000);
      chk("bp_ready", io_req_ready, 1'b0);
    end
    cycle(3'b000, 1'b0, 1'b0, 1'b1);
    chk("bp_valid_drop", io_resp_valid, 1'b0);
    read(1'b0, rd, ro);
    chk("bp_next", rd, 3'b100);
    chk("bp_next_ovf", ro, 4'd4);

    // Reset mid-response.
    cycle(3'b010, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", io_resp_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", io_resp_valid, 1'b0);
    chk("mid_rst_irq", io_irq, 1'b0);
    chk("mid_rst_ready", io_req_ready, 1'b1);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    read(1'b0, rd, ro);
    chk("post_rst_data", rd, 3'b000);
    chk("post_rst_ovf", ro, 4'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      cycle(s, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
